// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and the IF/ID entry type
package pipe_pkg;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W = 32;
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0;
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fdq_mem.sv
// fdq_mem: register array with one write port and one asynchronous read port
module fdq_mem #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular IF->ID buffer with flush and optional NOP dropping
module fetch_decode_queue
  import pipe_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W = DEF_PC_W,
  parameter int DEPTH = 4,
  parameter bit DROP_NOP = 1'b1,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               enq_valid_i,
  output logic               enq_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               deq_valid_o,
  input  logic               deq_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [CW-1:0]      count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = INSTR_W + PC_W;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [W-1:0] head;
  logic empty, is_nop, store, pop;
  assign empty = count == '0;
  assign enq_ready_o = count != CW'(DEPTH);
  assign deq_valid_o = !empty;
  assign is_nop = DROP_NOP && instr_i == INSTR_W'(NOP_INSTR);
  assign store = enq_valid_i & enq_ready_o & !is_nop & !flush_i;
  assign pop = deq_valid_o & deq_ready_i & !flush_i;
  assign count_o = count;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(store) - CW'(pop);
    end
  fdq_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk(clk_i),
    .we(store),
    .waddr(wr_ptr),
    .wdata({instr_i, pc_i}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // stale storage is never exposed: outputs read as a bubble while empty
  assign instr_o = empty ? '0 : head[W-1:PC_W];
  assign pc_o = empty ? '0 : head[PC_W-1:0];
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed checks of the IF->ID queue, with and without NOP dropping
module tb_fetch_decode_queue;
  logic clk = 0, rst_n = 0, flush = 0, enq_valid = 0, deq_ready = 0;
  logic [31:0] instr = 0, pc = 0;
  logic q_enq_ready, q_deq_valid, z_enq_ready, z_deq_valid;
  logic [31:0] q_instr, q_pc, z_instr, z_pc;
  logic [2:0] q_count, z_count;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fetch_decode_queue #(.DROP_NOP(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .enq_valid_i(enq_valid),
    .enq_ready_o(q_enq_ready), .instr_i(instr), .pc_i(pc), .deq_valid_o(q_deq_valid),
    .deq_ready_i(deq_ready), .instr_o(q_instr), .pc_o(q_pc), .count_o(q_count)
  );
  fetch_decode_queue #(.DROP_NOP(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .enq_valid_i(enq_valid),
    .enq_ready_o(z_enq_ready), .instr_i(instr), .pc_i(pc), .deq_valid_o(z_deq_valid),
    .deq_ready_i(deq_ready), .instr_o(z_instr), .pc_o(z_pc), .count_o(z_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] i, input logic [31:0] p);
    enq_valid = 1; instr = i; pc = p;
    cyc;
    enq_valid = 0;
  endtask
  initial begin
    cyc; cyc;
    chk("rst_count", q_count, 0);
    chk("rst_ready", q_enq_ready, 1);
    chk("rst_valid", q_deq_valid, 0);
    rst_n = 1;
    cyc;
    for (int i = 0; i < 3; i++) push(32'h100 + i, i * 4);
    chk("pre_rst_count", q_count, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_count", q_count, 0);
    chk("arst_valid", q_deq_valid, 0);
    chk("arst_instr", q_instr, 0);
    chk("arst_pc", q_pc, 0);
    chk("arst_ready", q_enq_ready, 1);
    cyc; rst_n = 1; cyc;
    deq_ready = 0;
    for (int i = 0; i < 4; i++) push(32'hA0 + i, i * 4);
    chk("full_count", q_count, 4);
    chk("full_ready", q_enq_ready, 0);
    enq_valid = 1; instr = 32'hA4; pc = 32'h10;
    cyc; cyc;
    chk("full_hold_count", q_count, 4);
    chk("full_hold_head", q_pc, 0);
    deq_ready = 1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_pc", q_pc, i * 4);
      chk("drain_instr", q_instr, 32'hA0 + i);
      cyc;
      if (i == 1) enq_valid = 0;
    end
    chk("drain_empty", q_deq_valid, 0);
    enq_valid = 1;
    for (int i = 0; i < 10; i++) begin
      instr = 32'hC00 + i; pc = 32'h100 + 4 * i;
      cyc;
      chk("wrap_count", q_count, 1);
      chk("wrap_pc", q_pc, 32'h100 + 4 * i);
      chk("wrap_instr", q_instr, 32'hC00 + i);
    end
    enq_valid = 0;
    cyc;
    chk("wrap_end", q_count, 0);
    deq_ready = 0;
    push(32'hD0, 32'h30);
    push(32'hD1, 32'h34);
    chk("pre_flush_count", q_count, 2);
    flush = 1; enq_valid = 1; instr = 32'hD2; pc = 32'h38; deq_ready = 1;
    chk("flush_ready", q_enq_ready, 1);
    cyc;
    flush = 0; enq_valid = 0; deq_ready = 0;
    chk("flush_count", q_count, 0);
    chk("flush_valid", q_deq_valid, 0);
    chk("flush_instr", q_instr, 0);
    chk("flush_pc", q_pc, 0);
    push(32'h00500093, 32'h40);
    chk("post_flush_count", q_count, 1);
    chk("post_flush_instr", q_instr, 32'h00500093);
    chk("post_flush_pc", q_pc, 32'h40);
    deq_ready = 1; cyc; deq_ready = 0;
    chk("post_flush_drain", q_count, 0);
    push(32'hE0, 32'h1C);
    enq_valid = 1; instr = 0; pc = 32'h20;
    chk("nop_ready", q_enq_ready, 1);
    cyc;
    enq_valid = 0;
    chk("nop_drop_count", q_count, 1);
    chk("nop_keep_count", z_count, 2);
    deq_ready = 1; cyc;
    chk("nop_drop_empty", q_count, 0);
    chk("nop_keep_valid", z_deq_valid, 1);
    chk("nop_keep_instr", z_instr, 0);
    chk("nop_keep_pc", z_pc, 32'h20);
    cyc;
    chk("nop_keep_drain", z_count, 0);
    deq_ready = 0;
    push(32'hF0, 32'h50);
    push(32'hF1, 32'h54);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("stall_pc", q_pc, 32'h50);
      chk("stall_instr", q_instr, 32'hF0);
      chk("stall_count", q_count, 2);
    end
    deq_ready = 1;
    cyc;
    chk("stall_next_pc", q_pc, 32'h54);
    chk("stall_next_instr", q_instr, 32'hF1);
    cyc;
    chk("stall_end", q_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
